// File: rtl/parity_frame_checker_pkg.sv
// rtl/parity_frame_checker_pkg.sv - shared UART parity modes, checker FSM states and parity helper
package parity_frame_checker_pkg;

    typedef logic [1:0] par_mode_t;
    typedef logic [1:0] state_t;

    localparam par_mode_t PAR_EVEN  = 2'b00;
    localparam par_mode_t PAR_ODD   = 2'b01;
    localparam par_mode_t PAR_MARK  = 2'b10;
    localparam par_mode_t PAR_SPACE = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    // running is the XOR of all data bits of the frame
    function automatic logic expected_parity(input par_mode_t mode, input logic running);
        case (mode)
            PAR_EVEN: return running;
            PAR_ODD:  return ~running;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/parity_frame_checker_sat_counter.sv
// rtl/parity_frame_checker_sat_counter.sv - saturating counter with synchronous clear taking priority before increment
module sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;
    logic [CNT_WIDTH-1:0] base;

    // A clear and an increment in the same cycle leave the counter at one
    always_comb begin
        base    = clr ? '0 : count_q;
        count_d = base;
        if (inc && (base != '1)) begin
            count_d = base + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/parity_frame_checker.sv
// rtl/parity_frame_checker.sv - serial frame assembler with configurable parity check and error statistics
module parity_frame_checker
    import parity_frame_checker_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  bit_valid,
    input  logic                  sampled_bit,
    input  logic                  PAR_EN,
    input  logic [1:0]            PAR_MODE,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  par_err_sticky,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic                  busy
);

    localparam int              BCW      = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0]  LAST_BIT = BCW'(DATA_WIDTH - 1);

    logic [1:0]            state_q, state_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  run_par_q, run_par_d;
    logic                  par_en_q, par_en_d;
    par_mode_t             par_mode_q, par_mode_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  par_err_q, par_err_d;
    logic                  data_valid_q, data_valid_d;
    logic                  sticky_q, sticky_d;

    logic                  frame_done;
    logic                  frame_err;
    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        run_par_d    = run_par_q;
        par_en_d     = par_en_q;
        par_mode_d   = par_mode_q;
        p_data_d     = p_data_q;
        par_err_d    = par_err_q;
        data_valid_d = 1'b0;
        frame_done   = 1'b0;
        frame_err    = 1'b0;

        // New bits enter at the MSB so the first received bit ends up at bit 0
        shifted                 = shreg_q >> 1;
        shifted[DATA_WIDTH-1]   = sampled_bit;

        if (start) begin
            state_d    = ST_DATA;
            bit_cnt_d  = '0;
            shreg_d    = '0;
            run_par_d  = 1'b0;
            par_en_d   = PAR_EN;
            par_mode_d = PAR_MODE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_DATA: begin
                    if (bit_valid) begin
                        shreg_d   = shifted;
                        run_par_d = run_par_q ^ sampled_bit;
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            if (par_en_q) begin
                                state_d = ST_PARITY;
                            end else begin
                                state_d    = ST_IDLE;
                                frame_done = 1'b1;
                                p_data_d   = shifted;
                            end
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_valid) begin
                        frame_err  = sampled_bit != expected_parity(par_mode_q, run_par_q);
                        frame_done = 1'b1;
                        state_d    = ST_IDLE;
                        p_data_d   = shreg_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (frame_done) begin
            data_valid_d = 1'b1;
            par_err_d    = frame_err;
        end

        sticky_d = (err_clr ? 1'b0 : sticky_q) | (frame_done & frame_err);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            run_par_q    <= 1'b0;
            par_en_q     <= 1'b0;
            par_mode_q   <= PAR_EVEN;
            p_data_q     <= '0;
            par_err_q    <= 1'b0;
            data_valid_q <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            run_par_q    <= run_par_d;
            par_en_q     <= par_en_d;
            par_mode_q   <= par_mode_d;
            p_data_q     <= p_data_d;
            par_err_q    <= par_err_d;
            data_valid_q <= data_valid_d;
            sticky_q     <= sticky_d;
        end
    end

    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_err_cnt (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (err_clr),
        .inc   (frame_done & frame_err),
        .count (err_cnt)
    );

    assign P_DATA         = p_data_q;
    assign data_valid     = data_valid_q;
    assign par_err        = par_err_q;
    assign par_err_sticky = sticky_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_parity_frame_checker.sv
// tb/tb_parity_frame_checker.sv - randomized and directed self-checking bench for parity_frame_checker
module tb_parity_frame_checker;

    logic       CLK = 1'b0;
    logic       RST;
    logic       start;
    logic       bit_valid;
    logic       sampled_bit;
    logic       PAR_EN;
    logic [1:0] PAR_MODE;
    logic       err_clr;

    logic [7:0] p_data_a, p_data_b;
    logic       dv_a, dv_b, perr_a, perr_b, sticky_a, sticky_b, busy_a, busy_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    always #5 CLK = ~CLK;

    parity_frame_checker #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut_a (
        .CLK(CLK), .RST(RST), .start(start), .bit_valid(bit_valid), .sampled_bit(sampled_bit),
        .PAR_EN(PAR_EN), .PAR_MODE(PAR_MODE), .err_clr(err_clr),
        .P_DATA(p_data_a), .data_valid(dv_a), .par_err(perr_a), .par_err_sticky(sticky_a),
        .err_cnt(cnt_a), .busy(busy_a)
    );

    parity_frame_checker #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut_b (
        .CLK(CLK), .RST(RST), .start(start), .bit_valid(bit_valid), .sampled_bit(sampled_bit),
        .PAR_EN(PAR_EN), .PAR_MODE(PAR_MODE), .err_clr(err_clr),
        .P_DATA(p_data_b), .data_valid(dv_b), .par_err(perr_b), .par_err_sticky(sticky_b),
        .err_cnt(cnt_b), .busy(busy_b)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a frame is a list of received bits plus the options seen at start
    bit       m_active;
    int       m_bits[$];
    bit       m_en;
    bit [1:0] m_mode;
    bit [7:0] e_pdata;
    bit       e_dv, e_perr, e_sticky;
    int       e_cnt_a, e_cnt_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_active = 0;
        m_bits.delete();
        m_en = 0;
        m_mode = 0;
        e_pdata = 0;
        e_dv = 0;
        e_perr = 0;
        e_sticky = 0;
        e_cnt_a = 0;
        e_cnt_b = 0;
    endfunction

    function automatic bit [7:0] model_word();
        bit [7:0] w = 0;
        foreach (m_bits[i]) w[i] = m_bits[i][0];
        return w;
    endfunction

    function automatic void model_complete(input bit err);
        e_pdata = model_word();
        e_perr = err;
        e_dv = 1;
        m_active = 0;
        if (err) begin
            e_sticky = 1;
            if (e_cnt_a < 255) e_cnt_a++;
            if (e_cnt_b < 3) e_cnt_b++;
        end
    endfunction

    function automatic void model_step(input bit s, input bit bv, input bit b, input bit clr,
                                       input bit en, input bit [1:0] mode);
        bit ones;
        bit expect_bit;
        e_dv = 0;
        if (clr) begin
            e_sticky = 0;
            e_cnt_a = 0;
            e_cnt_b = 0;
        end
        if (s) begin
            m_active = 1;
            m_bits.delete();
            m_en = en;
            m_mode = mode;
        end else if (m_active && bv) begin
            if (m_bits.size() < 8) begin
                m_bits.push_back(int'(b));
                if (m_bits.size() == 8 && !m_en) model_complete(1'b0);
            end else begin
                ones = bit'($countones(model_word()) % 2);
                case (m_mode)
                    2'd0: expect_bit = ones;
                    2'd1: expect_bit = !ones;
                    2'd2: expect_bit = 1'b1;
                    default: expect_bit = 1'b0;
                endcase
                model_complete(b != expect_bit);
            end
        end
    endfunction

    task automatic compare_all();
        check("dv_a", dv_a, e_dv);
        check("dv_b", dv_b, e_dv);
        check("p_data_a", p_data_a, e_pdata);
        check("p_data_b", p_data_b, e_pdata);
        check("par_err_a", perr_a, e_perr);
        check("par_err_b", perr_b, e_perr);
        check("sticky_a", sticky_a, e_sticky);
        check("sticky_b", sticky_b, e_sticky);
        check("err_cnt_a", cnt_a, e_cnt_a);
        check("err_cnt_b", cnt_b, e_cnt_b);
        check("busy_a", busy_a, m_active);
        check("busy_b", busy_b, m_active);
    endtask

    // Inputs change just after a falling edge; outputs are compared at the next falling edge
    task automatic cycle(input bit s, input bit bv, input bit b, input bit clr);
        start = s;
        bit_valid = bv;
        sampled_bit = b;
        err_clr = clr;
        model_step(s, bv, b, clr, PAR_EN, PAR_MODE);
        @(posedge CLK);
        @(negedge CLK);
        compare_all();
    endtask

    task automatic send_frame(input bit [7:0] data, input bit en, input bit [1:0] mode,
                              input bit pbit, input bit clr_last);
        PAR_EN = en;
        PAR_MODE = mode;
        cycle(1, 0, 0, 0);
        PAR_EN = 1'($urandom);
        PAR_MODE = 2'($urandom);
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 3) == 0) cycle(0, 0, 1'($urandom), 0);
            cycle(0, 1, data[i], clr_last && !en && i == 7);
        end
        if (en) cycle(0, 1, pbit, clr_last);
    endtask

    task automatic lit(input string name, input bit [7:0] pd, input bit pe, input bit st,
                       input int ca, input int cb);
        check({name, "_dv"}, dv_a, 1'b1);
        check({name, "_p_data"}, p_data_a, pd);
        check({name, "_par_err"}, perr_a, pe);
        check({name, "_sticky"}, sticky_a, st);
        check({name, "_cnt_a"}, cnt_a, ca);
        check({name, "_cnt_b"}, cnt_b, cb);
    endtask

    initial begin
        RST = 1'b0;
        start = 0;
        bit_valid = 0;
        sampled_bit = 0;
        PAR_EN = 0;
        PAR_MODE = 0;
        err_clr = 0;
        model_reset();
        @(negedge CLK);
        check("reset_p_data", p_data_a, 8'h00);
        check("reset_dv", dv_a, 1'b0);
        check("reset_busy", busy_a, 1'b0);
        check("reset_cnt", cnt_a, 8'h00);
        check("reset_sticky", sticky_a, 1'b0);
        compare_all();
        RST = 1'b1;
        cycle(0, 0, 0, 0);

        send_frame(8'hA5, 1, 2'b00, 0, 0);  lit("even_ok",  8'hA5, 0, 0, 0, 0);
        send_frame(8'hA5, 1, 2'b00, 1, 0);  lit("even_bad", 8'hA5, 1, 1, 1, 1);
        cycle(0, 0, 0, 0);
        check("dv_one_cycle", dv_a, 1'b0);
        send_frame(8'h07, 1, 2'b01, 0, 0);  lit("odd_ok",   8'h07, 0, 1, 1, 1);
        send_frame(8'h00, 1, 2'b10, 0, 0);  lit("mark_bad", 8'h00, 1, 1, 2, 2);
        send_frame(8'h00, 1, 2'b11, 1, 0);  lit("space_bad", 8'h00, 1, 1, 3, 3);
        send_frame(8'h3C, 0, 2'b00, 0, 0);  lit("no_par",   8'h3C, 0, 1, 3, 3);

        cycle(0, 0, 0, 1);
        check("clr_sticky", sticky_a, 1'b0);
        check("clr_cnt", cnt_a, 8'h00);
        check("clr_keeps_par_err", perr_a, 1'b0);

        for (int i = 0; i < 5; i++) send_frame(8'h00, 1, 2'b10, 0, 0);
        lit("sat", 8'h00, 1, 1, 5, 3);
        send_frame(8'h00, 1, 2'b10, 0, 1);
        lit("clr_with_err", 8'h00, 1, 1, 1, 1);

        PAR_EN = 1;
        PAR_MODE = 2'b00;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0);
        send_frame(8'h5A, 1, 2'b00, 0, 0);
        lit("abort_restart", 8'h5A, 0, 1, 1, 1);

        cycle(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 1'($urandom), 0);
        #2 RST = 1'b0;
        #1;
        check("async_rst_busy", busy_a, 1'b0);
        check("async_rst_p_data", p_data_a, 8'h00);
        check("async_rst_cnt", cnt_a, 8'h00);
        check("async_rst_sticky", sticky_a, 1'b0);
        check("async_rst_par_err", perr_a, 1'b0);
        model_reset();
        @(negedge CLK);
        compare_all();
        RST = 1'b1;
        send_frame(8'hC3, 1, 2'b00, 0, 0);
        lit("after_reset", 8'hC3, 0, 0, 0, 0);

        for (int n = 0; n < 4000; n++) begin
            PAR_EN = 1'($urandom);
            PAR_MODE = 2'($urandom);
            cycle($urandom_range(0, 59) == 0, 1'($urandom), 1'($urandom), $urandom_range(0, 59) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
- Serial-in parity checker that supersedes the fixed 8-bit even/odd checker.
- Assembles DATA_WIDTH sampled bits (LSB first), then checks the following parity bit in one of four modes.
- Reports a per-frame parity error, a sticky error flag and a saturating error counter.
- Sits between the UART RX bit sampler and the RX FSM/deserializer consumer; frame starts are driven by the RX FSM.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (>=1)
CNT_WIDTH, 8, width of saturating parity-error counter (>=1)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-low reset
start  input  1  frame-start strobe from RX FSM; begins a new frame
bit_valid  input  1  strobe: sampled_bit is valid this cycle
sampled_bit  input  1  current sampled serial bit
PAR_EN  input  1  1: frame carries a parity bit; 0: no parity bit
PAR_MODE  input  2  00 even, 01 odd, 10 mark (expect 1), 11 space (expect 0)
err_clr  input  1  clears par_err_sticky and err_cnt
P_DATA  output  DATA_WIDTH  assembled data word, LSB received first
data_valid  output  1  one-cycle pulse: frame complete, P_DATA/par_err valid
par_err  output  1  parity error of last completed frame
par_err_sticky  output  1  set on any parity error, held until err_clr
err_cnt  output  CNT_WIDTH  saturating count of parity errors
busy  output  1  high while in DATA or PARITY state

Behaviour:
- Reset (RST low, async): state IDLE; P_DATA=0, data_valid=0, par_err=0, par_err_sticky=0, err_cnt=0, busy=0; internal bit counter and running parity cleared. Reset mid-frame aborts the frame; no data_valid is produced.
- FSM states: IDLE, DATA, PARITY.
  - IDLE: bit_valid ignored. On start -> DATA; clear bit counter and running parity; latch PAR_EN and PAR_MODE for the whole frame.
  - DATA: on each bit_valid, shift sampled_bit into the shift register at MSB (after DATA_WIDTH shifts the first bit sits at bit 0), XOR it into the running parity, and increment the counter.
  - DATA, on the bit_valid that makes count==DATA_WIDTH:
    - latched PAR_EN=1 -> PARITY;
    - latched PAR_EN=0 -> IDLE, with frame-complete actions (par_err forced 0).
  - PARITY: on bit_valid, compute err = (sampled_bit != expected), then -> IDLE with frame-complete actions.
    - Expected parity: even = running parity; odd = ~running parity; mark = 1; space = 0.
- Frame-complete actions, registered at the accepting edge and visible the next cycle:
  - P_DATA <= shift register;
  - par_err <= err;
  - data_valid = 1 for exactly one cycle;
  - if err: par_err_sticky <= 1 and err_cnt increments, saturating at 2^CNT_WIDTH-1.
- Latency: data_valid asserts in the cycle after the last accepted bit (parity bit, or last data bit when PAR_EN=0).
- P_DATA and par_err hold their values until the next frame completes.
- start while busy: the current frame is aborted without data_valid and restarts as a fresh frame in DATA. start and bit_valid in the same cycle: start wins and that bit is discarded.
- PAR_EN/PAR_MODE changes mid-frame have no effect until the next start.
- err_clr coincident with a frame error: clear is applied first, then the error, giving par_err_sticky=1 and err_cnt=1. err_clr does not affect par_err, P_DATA or the FSM.
- busy = (state != IDLE), combinational from the state register.
- Internal widths:
  - bit counter is $clog2(DATA_WIDTH+1) bits;
  - counter wrap is impossible because DATA exits at DATA_WIDTH.

Decomposition:
- Shared UART package:
  - PAR_MODE encodings (PAR_EVEN=2'b00, PAR_ODD=2'b01, PAR_MARK=2'b10, PAR_SPACE=2'b11);
  - FSM state encodings for this block.
- One natural sub-module, sat_counter, holds the CNT_WIDTH saturating counter with synchronous clear and increment. The clear-then-increment priority rule lives there.

Test Plan:
- DATA_WIDTH=8, PAR_EN=1, even: send 0xA5 LSB first, parity 0 -> P_DATA=0xA5, par_err=0, data_valid one cycle; resend with parity 1 -> par_err=1, sticky=1, err_cnt=1.
- Odd mode, data 0x07, parity 0 -> par_err=0. Mark mode, data 0x00, parity 0 -> par_err=1. Space mode, parity 1 -> par_err=1.
- PAR_EN=0, data 0x3C -> data_valid the cycle after the 8th bit, par_err=0, err_cnt unchanged.
- CNT_WIDTH=2: five consecutive parity errors -> err_cnt=3 (saturated); err_clr concurrent with a sixth error -> err_cnt=1, sticky=1.
- Send 3 data bits, pulse start, then a full frame 0x5A even with correct parity -> a single data_valid, P_DATA=0x5A, par_err=0.
- Assert RST mid-frame after 4 bits -> all outputs 0 immediately, busy=0, no data_valid; next full frame decodes correctly.
